pattern_det: RTL and testbench
==============================

// Module: pattern_det
// PURPOSE
//  Parametrised serial sequence detector, successor to the fixed 2-state pulse-pair FSM.
//  Detects a runtime-loadable PAT_W-bit pattern on a 1-bit stream qualified by din_vld.
//  Supports overlapping and non-overlapping detection, a registered match pulse and a
//  saturating match counter. Sits between a serial front end and a status/IRQ block.
// PARAMETERS
//  PAT_W  4  pattern length in bits (2..32)
//  CNT_W  8  match counter width (>=1)
// PORTS
//  clk        in   1      clock, all logic on posedge
//  rst        in   1      asynchronous, active-low reset
//  load       in   1      capture pat_in/overlap; restart detection
//  pat_in     in   PAT_W  pattern; bit PAT_W-1 = first (oldest) bit received
//  overlap    in   1      1 = overlapping matches allowed; captured on load
//  din_vld    in   1      din is a valid stream bit this cycle
//  din        in   1      serial data bit
//  clr_cnt    in   1      synchronous clear of match_cnt and cnt_sat
//  dout       out  1      one-cycle match pulse
//  match_cnt  out  CNT_W  matches since reset/clr_cnt, saturating
//  cnt_sat    out  1      sticky: match_cnt reached all-ones
//  busy       out  1      1 when state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; pat_q=0; ovl_q=0; shreg=0; fill=0;
//   dout=0; match_cnt=0; cnt_sat=0; busy=0. Reset mid-stream discards all history.
//  FSM states: IDLE, FILL, SCAN.
//   IDLE: din ignored; load -> FILL (pat_q<=pat_in, ovl_q<=overlap, fill<=0, shreg<=0).
//   FILL: each din_vld: shreg<={shreg[PAT_W-2:0],din}, fill++; when fill reaches PAT_W
//     -> SCAN; match check applies on the accepted bit that makes fill==PAT_W.
//   SCAN: each din_vld shifts shreg; match when shifted value == pat_q.
//   On match: ovl_q=1 -> stay SCAN, history kept; ovl_q=0 -> FILL, fill<=0.
//   load in FILL/SCAN: restart as from IDLE; din on that cycle is discarded.
//  Match condition = accepted bit completes PAT_W valid bits equal to pat_q
//   (din_vld gaps do not break a sequence; only valid bits count).
//  dout: registered, high exactly 1 cycle after the clock edge that accepts the
//   completing bit (latency 1); never high two cycles running unless back-to-back
//   valid bits each complete a match (overlap only, e.g. all-ones pattern).
//  match_cnt: +1 per match, same edge dout is set; holds at 2^CNT_W-1; cnt_sat set
//   when the value reaches all-ones, cleared only by clr_cnt or reset.
//   clr_cnt with a simultaneous match: clear wins; that match is not counted (dout still pulses).
//  din_vld=0: no shift, no state change. fill width = $clog2(PAT_W+1).
// STRUCTURE
//  pattern_det_pkg: typedef enum logic [1:0] {IDLE,FILL,SCAN} pd_state_t; output constants.
//  Sub-module sat_counter #(CNT_W) (clr, inc -> cnt, sat) for match_cnt/cnt_sat.
//  Top: state reg + next-state always_comb, shreg/fill regs, registered dout.
// TESTING
//  1 PAT_W=4, load pat=1011 ovl=0, stream 1,0,1,1 (vld each cycle) -> dout pulse 1 cycle
//    after 4th bit, match_cnt=1.
//  2 pat=1011 ovl=1, stream 1011011 -> dout after bits 4 and 7, match_cnt=2;
//    same with ovl=0 -> single pulse after bit 4, match_cnt=1.
//  3 pat=1111 ovl=1, six 1s -> dout high after bits 4,5,6 (3 consecutive cycles), cnt=3.
//  4 pat=1011, stream 1,0,(vld=0 x3),1,1 -> single match; vld gaps ignored.
//  5 CNT_W=2, 5 matches -> match_cnt=3, cnt_sat=1; clr_cnt -> 0/0; clr_cnt on match edge -> 0.
//  6 rst low after bits 1,0,1 then release, load, send 1 -> no dout; load mid-stream
//    with new pat=0110 discards history; busy=0 after reset until load.

Source files
------------

// File: rtl/pattern_det_pkg.sv
// Shared types and defaults for the serial pattern detector.
// Imported by the interface, the counter and the detector top.
package pattern_det_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      SCAN = 2'd2
   } pd_state_t;

   localparam int PAT_W_DEF = 4;
   localparam int CNT_W_DEF = 8;

   localparam logic DOUT_RST = 1'b0;
   localparam logic BUSY_IDLE = 1'b0;

endpackage

// File: rtl/pattern_det_if.sv
// Control, stream and status bundle of the pattern detector.
// The master side drives the stream; the slave side is the detector.
interface pattern_det_if
   import pattern_det_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
);

   logic             load;
   logic [PAT_W-1:0] pat_in;
   logic             overlap;
   logic             din_vld;
   logic             din;
   logic             clr_cnt;
   logic             dout;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;
   logic             busy;

   modport master (
      output load, pat_in, overlap,
      output din_vld, din, clr_cnt,
      input  dout, match_cnt, cnt_sat, busy
   );

   modport slave (
      input  load, pat_in, overlap,
      input  din_vld, din, clr_cnt,
      output dout, match_cnt, cnt_sat, busy
   );

endinterface

// File: rtl/pattern_det_sat_counter.sv
// Saturating event counter with a sticky saturation flag.
// Clear takes priority over a simultaneous increment.
module sat_counter
   import pattern_det_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             sat_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   always_comb begin
      cnt_d = cnt_q;
      sat_d = sat_q;
      if (clr_i) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (inc_i && !(&cnt_q)) begin
         cnt_d = cnt_q + CNT_W'(1);
         sat_d = &cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         sat_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sat_q <= sat_d;
      end
   end

   assign cnt_o = cnt_q;
   assign sat_o = sat_q;

endmodule

// File: rtl/pattern_det.sv
// Serial sequence detector for a runtime-loaded pattern on a
// valid-qualified bit stream, with match pulse and match counter.
module pattern_det
   import pattern_det_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   pattern_det_if.slave bus
);

   localparam int FW = $clog2(PAT_W + 1);

   pd_state_t        state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic             ovl_q, ovl_d;
   logic [PAT_W-1:0] shreg_q, shreg_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             dout_q;
   logic             match;
   logic             full;
   logic [PAT_W-1:0] shifted;
   logic [FW-1:0]    fill_inc;

   assign shifted  = {shreg_q[PAT_W-2:0], bus.din};
   assign fill_inc = fill_q + FW'(1);

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      ovl_d   = ovl_q;
      shreg_d = shreg_q;
      fill_d  = fill_q;
      match   = 1'b0;
      full    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.load) begin
               state_d = FILL;
               pat_d   = bus.pat_in;
               ovl_d   = bus.overlap;
               shreg_d = '0;
               fill_d  = '0;
            end
         end
         FILL, SCAN: begin
            if (bus.load) begin
               state_d = FILL;
               pat_d   = bus.pat_in;
               ovl_d   = bus.overlap;
               shreg_d = '0;
               fill_d  = '0;
            end else if (bus.din_vld) begin
               shreg_d = shifted;
               if (state_q == FILL) fill_d = fill_inc;
               // Scan state means the window already holds PAT_W valid bits
               full  = (state_q == SCAN) || (fill_inc == FW'(PAT_W));
               match = full && (shifted == pat_q);
               if (match && !ovl_q) begin
                  state_d = FILL;
                  fill_d  = '0;
               end else if (full) begin
                  state_d = SCAN;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pat_q   <= '0;
         ovl_q   <= 1'b0;
         shreg_q <= '0;
         fill_q  <= '0;
         dout_q  <= DOUT_RST;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         shreg_q <= shreg_d;
         fill_q  <= fill_d;
         dout_q  <= match;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.clr_cnt),
      .inc_i (match),
      .cnt_o (bus.match_cnt),
      .sat_o (bus.cnt_sat)
   );

   assign bus.dout = dout_q;
   assign bus.busy = (state_q != IDLE) ? 1'b1 : BUSY_IDLE;

endmodule

// File: tb/tb_pattern_det.sv
// Scoreboard bench: two detectors (8- and 2-bit counters) share one
// stream; a behavioural model queues expected outputs per clock.
module tb_pattern_det;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   pattern_det_if #(.PAT_W(4), .CNT_W(8)) ifa ();
   pattern_det_if #(.PAT_W(4), .CNT_W(2)) ifb ();

   pattern_det #(.PAT_W(4), .CNT_W(8)) u_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   pattern_det #(.PAT_W(4), .CNT_W(2)) u_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   typedef struct {
      logic       dout;
      logic [7:0] ca;
      logic       sa;
      logic [1:0] cb;
      logic       sb;
      logic       busy;
   } exp_t;

   exp_t sb_q[$];

   int n_run  = 0;
   int n_fail = 0;

   logic        m_act;
   logic [3:0]  m_pat;
   logic        m_ovl;
   int          m_n;
   logic [31:0] m_bits;
   logic [7:0]  m_ca;
   logic        m_sa;
   logic [1:0]  m_cb;
   logic        m_sb;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic ld, input logic [3:0] p,
                        input logic ov, input logic v,
                        input logic d, input logic cl);
      ifa.load = ld; ifa.pat_in = p; ifa.overlap = ov;
      ifa.din_vld = v; ifa.din = d; ifa.clr_cnt = cl;
      ifb.load = ld; ifb.pat_in = p; ifb.overlap = ov;
      ifb.din_vld = v; ifb.din = d; ifb.clr_cnt = cl;
   endtask

   task automatic model_reset();
      m_act = 0; m_pat = '0; m_ovl = 0; m_n = 0; m_bits = '0;
      m_ca = '0; m_sa = 0; m_cb = '0; m_sb = 0;
   endtask

   task automatic model_push(input logic ld, input logic [3:0] p,
                             input logic ov, input logic v,
                             input logic d, input logic cl);
      exp_t e;
      logic hit;
      hit = 1'b0;
      if (ld) begin
         m_act = 1; m_pat = p; m_ovl = ov; m_n = 0; m_bits = '0;
      end else if (m_act && v) begin
         m_bits = {m_bits[30:0], d};
         m_n++;
         if (m_n >= 4 && m_bits[3:0] == m_pat) begin
            hit = 1'b1;
            if (!m_ovl) m_n = 0;
         end
      end
      if (cl) begin
         m_ca = '0; m_sa = 0; m_cb = '0; m_sb = 0;
      end else if (hit) begin
         if (m_ca != 8'hff) m_ca = m_ca + 8'd1;
         if (m_ca == 8'hff) m_sa = 1;
         if (m_cb != 2'd3) m_cb = m_cb + 2'd1;
         if (m_cb == 2'd3) m_sb = 1;
      end
      e.dout = hit; e.ca = m_ca; e.sa = m_sa;
      e.cb = m_cb; e.sb = m_sb; e.busy = m_act;
      sb_q.push_back(e);
   endtask

   task automatic step(input logic ld, input logic [3:0] p,
                       input logic ov, input logic v,
                       input logic d, input logic cl);
      exp_t e;
      @(negedge clk);
      drive(ld, p, ov, v, d, cl);
      model_push(ld, p, ov, v, d, cl);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk("dout_a", {31'd0, ifa.dout}, {31'd0, e.dout});
         chk("dout_b", {31'd0, ifb.dout}, {31'd0, e.dout});
         chk("cnt_a", {24'd0, ifa.match_cnt}, {24'd0, e.ca});
         chk("sat_a", {31'd0, ifa.cnt_sat}, {31'd0, e.sa});
         chk("cnt_b", {30'd0, ifb.match_cnt}, {30'd0, e.cb});
         chk("sat_b", {31'd0, ifb.cnt_sat}, {31'd0, e.sb});
         chk("busy", {30'd0, ifb.busy, ifa.busy}, {30'd0, e.busy, e.busy});
      end
   endtask

   task automatic bits(input logic [3:0] p, input logic ov,
                       input logic [15:0] s, input int n);
      step(1, p, ov, 0, 0, 0);
      for (int i = n - 1; i >= 0; i--) step(0, p, ov, 1, s[i], 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, '0, 0, 0, 0, 0);
      rst = 1'b0;
      #1;
      model_reset();
      chk("rst_dout", {31'd0, ifa.dout | ifb.dout}, 32'd0);
      chk("rst_cnt", {22'd0, ifa.match_cnt, ifb.match_cnt}, 32'd0);
      chk("rst_sat", {31'd0, ifa.cnt_sat | ifb.cnt_sat}, 32'd0);
      chk("rst_busy", {31'd0, ifa.busy | ifb.busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      drive(0, '0, 0, 0, 0, 0);
      model_reset();
      do_reset();

      // stream while idle is ignored
      step(0, 4'b1011, 0, 1, 1, 0);
      step(0, 4'b1011, 0, 1, 0, 0);

      bits(4'b1011, 0, 16'b1011, 4);
      bits(4'b1011, 1, 16'b1011011, 7);
      bits(4'b1011, 0, 16'b1011011, 7);
      bits(4'b1111, 1, 16'b111111, 6);

      // valid gaps inside a sequence
      step(1, 4'b1011, 0, 0, 0, 0);
      step(0, 4'b1011, 0, 1, 1, 0);
      step(0, 4'b1011, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 4'b1011, 0, 0, 1, 0);
      step(0, 4'b1011, 0, 1, 1, 0);
      step(0, 4'b1011, 0, 1, 1, 0);

      // saturation and clear
      step(0, 4'b0000, 0, 0, 0, 1);
      bits(4'b1111, 1, 16'hff, 8);
      step(0, 4'b1111, 1, 0, 0, 1);
      step(0, 4'b1111, 1, 1, 1, 1);
      step(0, 4'b1111, 1, 1, 1, 0);

      // reset mid-stream drops history
      step(1, 4'b1011, 0, 0, 0, 0);
      step(0, 4'b1011, 0, 1, 1, 0);
      step(0, 4'b1011, 0, 1, 0, 0);
      step(0, 4'b1011, 0, 1, 1, 0);
      do_reset();
      step(0, 4'b1011, 0, 1, 1, 0);
      step(1, 4'b1011, 0, 0, 0, 0);
      step(0, 4'b1011, 0, 1, 1, 0);
      step(0, 4'b1011, 0, 1, 0, 0);
      step(0, 4'b1011, 0, 1, 1, 0);
      // reload mid-stream; the bit on the load cycle is dropped
      step(1, 4'b0110, 0, 1, 1, 0);
      step(0, 4'b0110, 0, 1, 0, 0);
      step(0, 4'b0110, 0, 1, 1, 0);
      step(0, 4'b0110, 0, 1, 1, 0);
      step(0, 4'b0110, 0, 1, 0, 0);

      for (int i = 0; i < 400; i++) begin
         logic       ld, ov, v, d, cl;
         logic [3:0] p;
         ld = ($urandom_range(0, 31) == 0);
         cl = ($urandom_range(0, 47) == 0);
         v  = ($urandom_range(0, 3) != 0);
         d  = 1'($urandom);
         ov = 1'($urandom);
         p  = 4'($urandom);
         step(ld, p, ov, v, d, cl);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
